// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the memory responder: memory map, default
// geometry and the sequencer state encoding.
package mem_responder_pkg;

    localparam int          ADDR_W_DEF    = 10;
    localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;
    localparam logic [31:0] TOHOST_OFS    = 32'h0000_0000;
    localparam logic [31:0] CYCLES_OFS    = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// CPU instruction/data ports plus the host byte-stream loader port.
// master = CPU/host side, slave = memory responder.
interface mem_responder_if;

    logic [31:0] PC;
    logic [31:0] instruction;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_wr;
    logic [31:0] mem_read_data;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;

    modport master (
        output PC, mem_addr, mem_write_data, mem_wr,
        output ld_valid, ld_byte, ld_last,
        input  instruction, mem_read_data, ld_ready
    );

    modport slave (
        input  PC, mem_addr, mem_write_data, mem_wr,
        input  ld_valid, ld_byte, ld_last,
        output instruction, mem_read_data, ld_ready
    );

endinterface

// File: rtl/mem_responder_ld_packer.sv
// Packs host bytes big-endian into 32-bit words. A word is emitted on the
// beat carrying its 4th byte, or early (low bytes zero) when ld_last arrives.
module ld_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] acc_q, acc_d;

    // Merge the incoming byte into its lane and decide whether the word is complete.
    always_comb begin
        word = acc_q;
        case (byte_cnt_q)
            2'd0:    word = acc_q | {ld_byte, 24'h0};
            2'd1:    word = acc_q | {8'h0, ld_byte, 16'h0};
            2'd2:    word = acc_q | {16'h0, ld_byte, 8'h0};
            default: word = acc_q | {24'h0, ld_byte};
        endcase
        word_valid = accept && ((byte_cnt_q == 2'd3) || ld_last);

        byte_cnt_d = byte_cnt_q;
        acc_d      = acc_q;
        if (accept) begin
            if (word_valid) begin
                byte_cnt_d = 2'd0;
                acc_d      = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                acc_d      = word;
            end
        end
    end

    // Byte counter and partial-word accumulator; reset drops any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= 2'd0;
            acc_q      <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            acc_q      <= acc_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Unified word RAM (async read, sync write) with a TOHOST/CYCLES MMIO window
// and a host loader that fills RAM while the CPU is held in reset.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for the first loader byte, CPU held in reset
//   ST_LOAD | image streaming in, CPU held in reset
//   ST_RUN  | CPU released, stores and MMIO active, CYCLES counting
//   ST_HALT | nonzero TOHOST written, CPU held, CYCLES frozen until reset
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    output logic            cpu_reset,
    output logic            done,
    output logic [31:0]     tohost,
    output logic            addr_err
);

    localparam int DEPTH = 1 << ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   ld_ptr_q, ld_ptr_d;
    logic [31:0]       cycles_q, cycles_d;
    logic [31:0]       tohost_q, tohost_d;
    logic              addr_err_q, addr_err_d;

    logic [31:0]       ram [DEPTH];
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [31:0]       ram_wdata;

    logic              ld_accept;
    logic              pk_word_valid;
    logic [31:0]       pk_word;

    logic              pc_in_range, pc_mmio;
    logic              d_in_range, d_mmio, d_is_tohost, d_is_cycles;
    logic [ADDR_W-1:0] pc_idx, d_idx;
    logic              run;
    logic              ld_overflow;
    logic              unused_ok;

    assign run         = (state_q == ST_RUN);
    assign ld_accept   = bus.ld_valid && bus.ld_ready;
    assign ld_overflow = ld_ptr_q[ADDR_W];

    ld_packer u_ld_packer (
        .clk        (clk),
        .reset      (reset),
        .accept     (ld_accept),
        .ld_byte    (bus.ld_byte),
        .ld_last    (bus.ld_last),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    // Address decode for the fetch and data ports; byte offset bits are ignored.
    always_comb begin
        pc_in_range = (bus.PC[31:ADDR_W+2] == '0);
        pc_mmio     = (bus.PC[31:3] == MMIO_BASE[31:3]);
        pc_idx      = bus.PC[ADDR_W+1:2];
        d_in_range  = (bus.mem_addr[31:ADDR_W+2] == '0);
        d_mmio      = (bus.mem_addr[31:3] == MMIO_BASE[31:3]);
        d_idx       = bus.mem_addr[ADDR_W+1:2];
        d_is_tohost = d_mmio && (bus.mem_addr[2] == TOHOST_OFS[2]);
        d_is_cycles = d_mmio && (bus.mem_addr[2] == CYCLES_OFS[2]);
    end

    assign unused_ok = ^{bus.PC[1:0], bus.mem_addr[1:0]};

    // Combinational fetch and load paths.
    always_comb begin
        bus.instruction = pc_in_range ? ram[pc_idx] : '0;
        if (d_in_range) begin
            bus.mem_read_data = ram[d_idx];
        end else if (d_is_tohost) begin
            bus.mem_read_data = tohost_q;
        end else if (d_is_cycles) begin
            bus.mem_read_data = cycles_q;
        end else begin
            bus.mem_read_data = '0;
        end
    end

    // Single RAM write port shared by the loader (IDLE/LOAD) and CPU stores (RUN).
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (pk_word_valid && !ld_overflow) begin
            ram_we    = 1'b1;
            ram_waddr = ld_ptr_q[ADDR_W-1:0];
            ram_wdata = pk_word;
        end else if (run && bus.mem_wr && d_in_range) begin
            ram_we    = 1'b1;
            ram_waddr = d_idx;
            ram_wdata = bus.mem_write_data;
        end
    end

    // RAM storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // Loader pointer, MMIO registers, cycle counter and sticky error flag.
    always_comb begin
        ld_ptr_d   = ld_ptr_q;
        cycles_d   = cycles_q;
        tohost_d   = tohost_q;
        addr_err_d = addr_err_q;
        if (pk_word_valid) begin
            if (ld_overflow) begin
                addr_err_d = 1'b1;
            end else begin
                ld_ptr_d = ld_ptr_q + 1'b1;
            end
        end
        if (run) begin
            cycles_d = cycles_q + 32'd1;
            if (bus.mem_wr && d_is_tohost) begin
                tohost_d = bus.mem_write_data;
            end
            if ((!pc_in_range && !pc_mmio) || (!d_in_range && !d_mmio)) begin
                addr_err_d = 1'b1;
            end
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ld_accept) state_d = bus.ld_last ? ST_RUN : ST_LOAD;
            ST_LOAD: if (ld_accept && bus.ld_last) state_d = ST_RUN;
            ST_RUN:  if (bus.mem_wr && d_is_tohost && (bus.mem_write_data != '0)) state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // State and control register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ld_ptr_q   <= '0;
            cycles_q   <= '0;
            tohost_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_ptr_q   <= ld_ptr_d;
            cycles_q   <= cycles_d;
            tohost_q   <= tohost_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.ld_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign cpu_reset    = (state_q != ST_RUN);
    assign done         = (state_q == ST_HALT);
    assign tohost       = tohost_q;
    assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: loader, fetch/load/store, MMIO, errors.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_reset;
    logic        done;
    logic [31:0] tohost;
    logic        addr_err;
    int          checks = 0;
    int          errors = 0;

    mem_responder_if bus ();

    mem_responder #(
        .ADDR_W    (10),
        .MMIO_BASE (32'hFFFF_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .tohost    (tohost),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        bus.PC             = 32'h0;
        bus.mem_addr       = 32'h0;
        bus.mem_write_data = 32'h0;
        bus.mem_wr         = 1'b0;
        bus.ld_valid       = 1'b0;
        bus.ld_byte        = 8'h0;
        bus.ld_last        = 1'b0;
    endtask

    task automatic do_reset;
        idle_bus();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        bus.ld_last  = last;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b want 1", cpu_reset); end
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL rst_ld_ready got %b want 1", bus.ld_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (tohost !== 32'h0) begin errors++; $display("FAIL rst_tohost got %h want 0", tohost); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err got %b want 0", addr_err); end
        bus.mem_addr = 32'hFFFF_0004;
        #1;
        checks++; if (bus.mem_read_data !== 32'h0) begin errors++; $display("FAIL rst_cycles got %h want 0", bus.mem_read_data); end
        bus.mem_addr = 32'h0;
    endtask

    task automatic test_load_two_words;
        send_byte(8'h20, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL load_b7_cpu_reset got %b want 1", cpu_reset); end
        send_byte(8'h07, 1'b1);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL load_b8_cpu_reset got %b want 0", cpu_reset); end
        checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL load_run_ld_ready got %b want 0", bus.ld_ready); end
        bus.PC = 32'h0; #1;
        checks++; if (bus.instruction !== 32'h2001_0005) begin errors++; $display("FAIL load_ram0 got %h want 20010005", bus.instruction); end
        bus.PC = 32'h4; #1;
        checks++; if (bus.instruction !== 32'h0000_0007) begin errors++; $display("FAIL load_ram1 got %h want 00000007", bus.instruction); end
        bus.mem_addr = 32'h0; #1;
        checks++; if (bus.mem_read_data !== 32'h2001_0005) begin errors++; $display("FAIL load_data0 got %h want 20010005", bus.mem_read_data); end
        // First RUN cycle: CYCLES has not advanced yet.
        bus.mem_addr = 32'hFFFF_0004; #1;
        checks++; if (bus.mem_read_data !== 32'd0) begin errors++; $display("FAIL cycles_first got %0d want 0", bus.mem_read_data); end
        tick();
        checks++; if (bus.mem_read_data !== 32'd1) begin errors++; $display("FAIL cycles_second got %0d want 1", bus.mem_read_data); end
    endtask

    task automatic test_store_load;
        // Same-cycle store and fetch to ram[1]: fetch sees the old word.
        bus.PC             = 32'h4;
        bus.mem_addr       = 32'h4;
        bus.mem_write_data = 32'hCAFE_F00D;
        bus.mem_wr         = 1'b1;
        #1;
        checks++; if (bus.instruction !== 32'h0000_0007) begin errors++; $display("FAIL same_cycle_fetch got %h want 00000007", bus.instruction); end
        checks++; if (bus.mem_read_data !== 32'h0000_0007) begin errors++; $display("FAIL same_cycle_load got %h want 00000007", bus.mem_read_data); end
        tick(); // cycles -> 2
        bus.mem_wr = 1'b0;
        #1;
        checks++; if (bus.instruction !== 32'hCAFE_F00D) begin errors++; $display("FAIL store_visible got %h want cafef00d", bus.instruction); end
        bus.mem_addr       = 32'h10;
        bus.mem_write_data = 32'hDEAD_BEEF;
        bus.mem_wr         = 1'b1;
        tick(); // cycles -> 3
        bus.mem_wr = 1'b0;
        #1;
        checks++; if (bus.mem_read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_10 got %h want deadbeef", bus.mem_read_data); end
        bus.mem_addr = 32'h12; #1;
        checks++; if (bus.mem_read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_12 got %h want deadbeef", bus.mem_read_data); end
        // CYCLES is read-only.
        bus.mem_addr       = 32'hFFFF_0004;
        bus.mem_write_data = 32'd5;
        bus.mem_wr         = 1'b1;
        #1;
        checks++; if (bus.mem_read_data !== 32'd3) begin errors++; $display("FAIL cycles_before_wr got %0d want 3", bus.mem_read_data); end
        tick(); // cycles -> 4
        bus.mem_wr = 1'b0;
        #1;
        checks++; if (bus.mem_read_data !== 32'd4) begin errors++; $display("FAIL cycles_after_wr got %0d want 4", bus.mem_read_data); end
        checks++; if (tohost !== 32'h0) begin errors++; $display("FAIL cycles_wr_tohost got %h want 0", tohost); end
    endtask

    task automatic test_tohost;
        bus.mem_addr       = 32'hFFFF_0000;
        bus.mem_write_data = 32'h0;
        bus.mem_wr         = 1'b1;
        tick(); // cycles -> 5
        bus.mem_wr = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL tohost0_done got %b want 0", done); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL tohost0_cpu_reset got %b want 0", cpu_reset); end
        bus.mem_write_data = 32'h1;
        bus.mem_wr         = 1'b1;
        tick(); // cycles -> 6, now HALT
        bus.mem_wr = 1'b0;
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL tohost1_done got %b want 1", done); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL tohost1_cpu_reset got %b want 1", cpu_reset); end
        checks++; if (tohost !== 32'h1) begin errors++; $display("FAIL tohost1_value got %h want 1", tohost); end
        checks++; if (bus.mem_read_data !== 32'h1) begin errors++; $display("FAIL tohost_read got %h want 1", bus.mem_read_data); end
        bus.mem_addr = 32'hFFFF_0004; #1;
        checks++; if (bus.mem_read_data !== 32'd6) begin errors++; $display("FAIL cycles_halt got %0d want 6", bus.mem_read_data); end
        tick(); tick();
        checks++; if (bus.mem_read_data !== 32'd6) begin errors++; $display("FAIL cycles_frozen got %0d want 6", bus.mem_read_data); end
        checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL halt_ld_ready got %b want 0", bus.ld_ready); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL halt_addr_err got %b want 0", addr_err); end
    endtask

    task automatic test_short_last;
        do_reset();
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b1);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL short_run got %b want 0", cpu_reset); end
        bus.PC = 32'h0; #1;
        checks++; if (bus.instruction !== 32'hABCD_0000) begin errors++; $display("FAIL short_ram0 got %h want abcd0000", bus.instruction); end
    endtask

    task automatic test_addr_err;
        bus.mem_addr = 32'h0001_0000; #1;
        checks++; if (bus.mem_read_data !== 32'h0) begin errors++; $display("FAIL oor_data got %h want 0", bus.mem_read_data); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL oor_err_early got %b want 0", addr_err); end
        tick();
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL oor_err got %b want 1", addr_err); end
        bus.mem_addr = 32'h0;
        tick(); tick();
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL oor_sticky got %b want 1", addr_err); end
        do_reset();
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL oor_cleared got %b want 0", addr_err); end
    endtask

    task automatic test_reset_midword;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL mid_ld_ready got %b want 1", bus.ld_ready); end
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        bus.PC = 32'h0; #1;
        checks++; if (bus.instruction !== 32'h4455_6677) begin errors++; $display("FAIL mid_ram0 got %h want 44556677", bus.instruction); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL mid_cpu_reset got %b want 1", cpu_reset); end
    endtask

    task automatic test_overflow;
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            w = 32'h5A00_0000 | 32'(i);
            send_byte(w[31:24], 1'b0);
            send_byte(w[23:16], 1'b0);
            send_byte(w[15:8], 1'b0);
            send_byte(w[7:0], 1'b0);
        end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL full_err got %b want 0", addr_err); end
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b1);
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b want 1", addr_err); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL ovf_run got %b want 0", cpu_reset); end
        bus.PC = 32'h0; #1;
        checks++; if (bus.instruction !== 32'h5A00_0000) begin errors++; $display("FAIL ovf_ram0 got %h want 5a000000", bus.instruction); end
        bus.PC = 32'h4; #1;
        checks++; if (bus.instruction !== 32'h5A00_0001) begin errors++; $display("FAIL ovf_ram1 got %h want 5a000001", bus.instruction); end
        bus.PC = 32'hFFC; #1;
        checks++; if (bus.instruction !== 32'h5A00_03FF) begin errors++; $display("FAIL ovf_ram_last got %h want 5a0003ff", bus.instruction); end
        bus.PC = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        idle_bus();
        test_reset();
        test_load_two_words();
        test_store_load();
        test_tohost();
        test_short_last();
        test_addr_err();
        test_reset_midword();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
